// File: rtl/mem_pkg.sv
// Shared definitions for the line-memory responder: widths, FSM state type
// and default latency.
package mem_pkg;

  localparam int unsigned LINE_W      = 128;
  localparam int unsigned ADDR_W      = 28;
  localparam int unsigned DEF_LATENCY = 4;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_TURN
  } state_t;

  // Counter preload for a given latency (remaining BUSY cycles before DONE).
  function automatic logic [CNT_W-1:0] load_count(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line storage: MEM_NUM x LINE_W, one synchronous write port and one
// combinational read port. Contents are never reset.
module mem_line_array #(
  parameter int unsigned MEM_NUM = 256,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned IDX_W   = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [MEM_NUM];

  // Commit a line on the write strobe.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read of the addressed line.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line memory responder: accepts one read or write request,
// completes it LATENCY cycles later with a one-cycle mem_ready pulse, then
// spends one turnaround cycle ignoring requests.
// Optional feature: define MEM_RESPONDER_STATS_EN to add rd_count/wr_count.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_NUM = 256,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int unsigned IDX_W = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  localparam logic [CNT_W-1:0] LOAD = load_count(LATENCY);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   idx;
  logic [LINE_W-1:0]  wdata_q;
  logic               op_wr;
  logic               arr_we;
  logic [IDX_W-1:0]   arr_raddr;
  logic [LINE_W-1:0]  arr_rdata;
  logic               unused_addr;

  assign unused_addr = ^mem_addr[ADDR_W-1:IDX_W];

  // Read address: live request address in IDLE so a LATENCY=1 read can
  // capture data on its accept edge; latched index otherwise.
  always_comb begin
    arr_raddr = (state == ST_IDLE) ? mem_addr[IDX_W-1:0] : idx;
  end

  // Write commits at the end of DONE unless a reset discards it.
  always_comb begin
    arr_we = (state == ST_DONE) && op_wr && !proc_reset;
  end

  mem_line_array #(
    .MEM_NUM (MEM_NUM),
    .LINE_W  (LINE_W),
    .IDX_W   (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (idx),
    .wdata (wdata_q),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  // Request FSM, latency counter and registered outputs.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      idx       <= '0;
      wdata_q   <= '0;
      op_wr     <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_read || mem_write) begin
            idx     <= mem_addr[IDX_W-1:0];
            wdata_q <= mem_wdata;
            op_wr   <= mem_write;
            count   <= LOAD;
            if (LATENCY == 1) begin
              state     <= ST_DONE;
              mem_ready <= 1'b1;
              if (!mem_write) mem_rdata <= arr_rdata;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          count <= count - 1'b1;
          if (count <= CNT_W'(1)) begin
            state     <= ST_DONE;
            mem_ready <= 1'b1;
            if (!op_wr) mem_rdata <= arr_rdata;
          end
        end
        ST_DONE: state <= ST_TURN;
        ST_TURN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  // Completed-operation counters, bumped as each operation leaves DONE.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == ST_DONE) begin
      if (op_wr) wr_count <= wr_count + 1'b1;
      else       rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (LATENCY=4 main instance, LATENCY=1
// timing instance). Stats outputs are checked when MEM_RESPONDER_STATS_EN
// is defined.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset, mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_read1, mem_write1, mem_ready1;
  logic [27:0]  mem_addr1;
  logic [127:0] mem_wdata1, mem_rdata1;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0]  rd_count, wr_count, rd_count1, wr_count1;
`endif

  mem_responder #(.MEM_NUM(256), .LATENCY(LAT)) dut (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  mem_responder #(.MEM_NUM(256), .LATENCY(1)) dut1 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read1), .mem_write(mem_write1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
  );

  typedef struct {
    int unsigned  exp_cyc;
    logic [127:0] exp_data;
    int unsigned  id;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int unsigned  cyc = 0;
  int           tests = 0;
  int           fails = 0;
  int unsigned  op_id = 0;
  int unsigned  n_rd = 0;
  int unsigned  n_wr = 0;
  logic [127:0] model [256];
  logic [127:0] last_rdata = '0;
  logic         prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every mem_ready pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (mem_ready) begin
      tests++;
      if (prev_ready) begin
        fails++;
        $display("FAIL ready_width: ready high again at cyc %0d, required single-cycle pulse", cyc);
      end
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ready: ready=1 at cyc %0d, required no pending op", cyc);
      end else begin
        e = sb.pop_front();
        tests++;
        if (cyc != e.exp_cyc) begin
          fails++;
          $display("FAIL ready_cycle op%0d: got cyc %0d, required cyc %0d", e.id, cyc, e.exp_cyc);
        end
        tests++;
        if (mem_rdata !== e.exp_data) begin
          fails++;
          $display("FAIL rdata op%0d: got %h, required %h", e.id, mem_rdata, e.exp_data);
        end
      end
    end
    prev_ready = mem_ready;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL ready_timeout: no mem_ready within 40 cycles at cyc %0d, required a pulse", cyc);
    end
  endtask

  // Issue one operation at a negedge with the DUT idle; returns at a negedge
  // with inputs low and the DUT idle again.
  task automatic run_op(input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, input bit hold, input bit drop_early);
    exp_t x;
    int unsigned ix;
    ix = int'(a[7:0]);
    x.exp_cyc = cyc + LAT;
    x.id = op_id++;
    if (wr) begin
      model[ix] = d;
      x.exp_data = last_rdata;
      n_wr++;
    end else begin
      x.exp_data = model[ix];
      last_rdata = model[ix];
      n_rd++;
    end
    sb.push_back(x);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
    if (drop_early) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0; mem_addr = ~a; mem_wdata = ~d;
    end
    wait_ready();
    @(negedge clk);
    if (hold) @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    if (!hold) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line5, pat_a5;
    exp_t x;
    line5  = 128'h00000003_00000002_00000001_00000000;
    pat_a5 = {16{8'hA5}};
    proc_reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_read1 = 1'b0; mem_write1 = 1'b0; mem_addr1 = '0; mem_wdata1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdata", mem_rdata, '0);
    chk("reset_ready", {127'b0, mem_ready}, '0);
    proc_reset = 1'b0;
    @(negedge clk);

    // Preload and read back, write/read with aliasing.
    run_op(1'b0, 1'b1, 28'd5, line5, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 28'd5, '0, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 28'd7, pat_a5, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 28'd7, '0, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 28'd263, '0, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 28'h0ABC_D07, '0, 1'b0, 1'b0);

    // Read and write together: write wins, rdata untouched.
    run_op(1'b1, 1'b1, 28'd3, 128'h1, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 28'd3, '0, 1'b0, 1'b0);

    // Request held through turnaround, then an immediate follow-on read.
    run_op(1'b1, 1'b0, 28'd7, '0, 1'b1, 1'b0);
    run_op(1'b1, 1'b0, 28'd5, '0, 1'b0, 1'b0);

    // Request dropped and inputs scrambled right after accept.
    run_op(1'b0, 1'b1, 28'd20, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 1'b0, 1'b1);
    run_op(1'b1, 1'b0, 28'd20, '0, 1'b0, 1'b1);

    // Reset during BUSY discards the write to line 9.
    run_op(1'b0, 1'b1, 28'd9, 128'h9999_0000_1111_2222_3333_4444_5555_6666, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 28'd20, '0, 1'b0, 1'b0);
    mem_write = 1'b1; mem_addr = 28'd9; mem_wdata = '1;
    @(negedge clk);
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0; mem_write = 1'b0;
    chk("busy_reset_ready", {127'b0, mem_ready}, '0);
    chk("busy_reset_rdata", mem_rdata, '0);
    last_rdata = '0; n_rd = 0; n_wr = 0;
    repeat (8) @(negedge clk);
    run_op(1'b1, 1'b0, 28'd9, '0, 1'b0, 1'b0);

    // Reset in DONE: pulse is seen but the write to line 11 is dropped.
    run_op(1'b0, 1'b1, 28'd11, 128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0, 1'b0);
    x.exp_cyc = cyc + LAT;
    x.exp_data = last_rdata;
    x.id = op_id++;
    sb.push_back(x);
    mem_write = 1'b1; mem_addr = 28'd11; mem_wdata = 128'h2222;
    wait_ready();
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0; mem_write = 1'b0;
    chk("done_reset_rdata", mem_rdata, '0);
    last_rdata = '0; n_rd = 0; n_wr = 0;
    @(negedge clk);
    run_op(1'b1, 1'b0, 28'd11, '0, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 28'd12, 128'hC0FFEE, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 28'd12, '0, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 28'd5, '0, 1'b0, 1'b0);

    // LATENCY=1 instance: ready on the cycle right after accept.
    mem_write1 = 1'b1; mem_addr1 = 28'd2; mem_wdata1 = 128'h5A5A;
    @(negedge clk);
    chk("lat1_wr_ready", {127'b0, mem_ready1}, 128'h1);
    @(negedge clk);
    mem_write1 = 1'b0;
    chk("lat1_ready_width", {127'b0, mem_ready1}, '0);
    @(negedge clk);
    mem_read1 = 1'b1;
    @(negedge clk);
    chk("lat1_rd_ready", {127'b0, mem_ready1}, 128'h1);
    chk("lat1_rdata", mem_rdata1, 128'h5A5A);
    @(negedge clk);
    mem_read1 = 1'b0;

    repeat (6) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), '0);
`ifdef MEM_RESPONDER_STATS_EN
    chk("rd_count", {96'b0, rd_count}, 128'(n_rd));
    chk("wr_count", {96'b0, wr_count}, 128'(n_wr));
    chk("rd_count1", {96'b0, rd_count1}, 128'h1);
    chk("wr_count1", {96'b0, wr_count1}, 128'h1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_NUM, default 256, number of 128-bit lines stored.
REQ-002 Parameter LATENCY, default 4, cycles from request accept to mem_ready; legal range 1..15.
REQ-003 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 Port proc_reset, input, 1, synchronous active-high reset.
REQ-005 Port mem_read, input, 1, line read request, held by initiator until mem_ready seen.
REQ-006 Port mem_write, input, 1, line write request, held by initiator until mem_ready seen.
REQ-007 Port mem_addr, input, 28, line address.
REQ-008 Port mem_wdata, input, 128, write line data.
REQ-009 Port mem_rdata, output, 128, read line data.
REQ-010 Port mem_ready, output, 1, one-cycle completion pulse.

Function
REQ-011 FSM states IDLE, BUSY, DONE, TURN; reset state IDLE.
REQ-012 IDLE: mem_read or mem_write high at a clock edge -> accept: latch addr, wdata, op; load counter with LATENCY-1; go BUSY (LATENCY=1 -> go DONE directly).
REQ-013 Both mem_read and mem_write high at accept -> write performed, read ignored, mem_rdata unchanged.
REQ-014 BUSY: counter decrements each cycle; at 1 -> DONE next cycle.
REQ-015 DONE: mem_ready=1 for exactly this one cycle; read -> mem_rdata driven with array[index] in the same cycle; write -> array[index] <= latched wdata at end of cycle; next state TURN.
REQ-016 Accept cycle T -> mem_ready high in cycle T+LATENCY.
REQ-017 TURN: one cycle, requests ignored (initiator still holding request while it registers mem_ready); next state IDLE.
REQ-018 Request inputs changing or dropping after accept are ignored; the accepted operation completes and mem_ready still pulses.
REQ-019 mem_rdata holds its value outside DONE until the next read completes; writes never change it.
REQ-020 index = mem_addr mod MEM_NUM (low log2(MEM_NUM) bits); upper address bits ignored, addresses alias/wrap.
REQ-021 Read of a line written by the immediately preceding operation returns the new data.

Reset
REQ-022 proc_reset high at an edge: state IDLE, mem_ready=0, mem_rdata=0, counter=0, latched request cleared; applies in any state.
REQ-023 Reset during BUSY/DONE discards the pending operation (write not committed, no mem_ready pulse); array contents never reset.

Configuration
REQ-024 Macro MEM_RESPONDER_STATS_EN defined -> extra outputs rd_count[31:0], wr_count[31:0], each incremented in DONE for its op, reset to 0, wrapping at 2^32.
REQ-025 Macro undefined -> those ports and counters absent; all other behaviour identical.

Structure
REQ-026 Package mem_pkg holds LINE_W=128, ADDR_W=28, the FSM state typedef and the default LATENCY.
REQ-027 Storage in sub-module mem_line_array (MEM_NUM x LINE_W, one synchronous write port, one combinational read port); FSM/counter in mem_responder.

Verification
REQ-028 Preload line 5 = 128'h3_00000002_00000001_00000000 style pattern, read addr 5 with LATENCY=4 -> mem_ready at accept+4, rdata = preloaded line, ready width 1.
REQ-029 Write addr 7 data 128'hA5..A5, then read addr 7 -> rdata 128'hA5..A5; read addr 7+256 -> same data (alias).
REQ-030 mem_read and mem_write both high, addr 3, wdata 128'h1 -> line 3 = 1, mem_rdata unchanged from prior value.
REQ-031 Initiator holds mem_read one cycle past mem_ready -> no second accept; next accept no earlier than ready+2.
REQ-032 Write addr 9 accepted, proc_reset pulsed in BUSY -> no mem_ready, line 9 unchanged, mem_rdata=0, state IDLE.
REQ-033 MEM_RESPONDER_STATS_EN build, 3 reads + 2 writes -> rd_count=3, wr_count=2; LATENCY=1 build -> ready at accept+1.
